tdm_demux4: RTL

//  Receive end of the 4:1 multiplexed link: one shared data line carries channels a,b,c,d

---
 rtl/tdm_demux4.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive end of a 4:1 time-division multiplexed link.
//
// One shared data line carries channels a, b, c, d round-robin, one beat per
// slot, with the slot-0 beat flagged by sof. The block hunts for sof, tracks
// the slot, stages slots 0..2, and on the slot-3 beat loads all four channel
// outputs in a single edge so a..d always present one complete frame.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   inp          in   WIDTH  multiplexed data beat
//   in_valid     in   1      inp/sof valid this cycle; low = no state advance
//   sof          in   1      start of frame (legal only on the slot-0 beat)
//   a,b,c,d      out  WIDTH  channels 0..3 of the last complete frame
//   s            out  2      slot index expected for the next accepted beat
//   frame_valid  out  1      one-cycle pulse: a..d just loaded with a frame
//   sync_err     out  1      one-cycle pulse: framing violation detected
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inp,
  input  logic             in_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       s,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] stg_p0 [0:2];
  logic             wr_en;
  logic [1:0]       wr_idx;
  logic             load;
  logic             fv_d, se_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    wr_en   = 1'b0;
    wr_idx  = s_q;
    load    = 1'b0;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          // Beats without sof are dropped silently while hunting.
          if (sof) begin
            wr_en   = 1'b1;
            wr_idx  = 2'd0;
            s_d     = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (s_q == 2'd0) begin
            if (sof) begin
              wr_en  = 1'b1;
              wr_idx = 2'd0;
              s_d    = 2'd1;
            end else begin
              // Missing sof where a frame must start: lose lock.
              se_d    = 1'b1;
              s_d     = 2'd0;
              state_d = HUNT;
            end
          end else if (sof) begin
            // Early sof: drop the partial frame and resync on this beat.
            // Slots 1..2 of the old frame are overwritten before any load.
            se_d   = 1'b1;
            wr_en  = 1'b1;
            wr_idx = 2'd0;
            s_d    = 2'd1;
          end else if (s_q == 2'd3) begin
            load = 1'b1;
            fv_d = 1'b1;
            s_d  = 2'd0;
          end else begin
            wr_en = 1'b1;
            s_d   = s_q + 2'd1;
          end
        end
        default: begin
          state_d = HUNT;
          s_d     = 2'd0;
        end
      endcase
    end
  end

  // Stage p0: slot staging / stage p1: frame output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      s_q         <= 2'd0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      stg_p0[0]   <= '0;
      stg_p0[1]   <= '0;
      stg_p0[2]   <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      frame_valid <= fv_d;
      sync_err    <= se_d;
      if (wr_en && (wr_idx != 2'd3)) begin
        stg_p0[wr_idx] <= inp;
      end
      if (load) begin
        a <= stg_p0[0];
        b <= stg_p0[1];
        c <= stg_p0[2];
        d <= inp;
      end
    end
  end

  assign s = s_q;

endmodule
